// File: rtl/idli_sqi_resp_m.sv
// SQI (quad SPI) responder with a small byte store: read 0x03 / write 0x02,
// 24-bit MSB-first address, DUMMY_NIB dummy nibbles before read data.
// Ports: i_srsp_gck/i_srsp_rst clock and async active-high reset;
//        i_srsp_sck/i_srsp_cs/i_srsp_sio from the initiator;
//        o_srsp_sio/o_srsp_sio_oe read-data drive; o_srsp_err sticky bad-command flag.
typedef logic [3:0] sqi_data_t;

module idli_sqi_resp_m #(
    parameter int ADDR_W    = 8,
    parameter int DUMMY_NIB = 2
) (
    input  logic      i_srsp_gck,
    input  logic      i_srsp_rst,
    input  logic      i_srsp_sck,
    input  logic      i_srsp_cs,
    input  sqi_data_t i_srsp_sio,
    output sqi_data_t o_srsp_sio,
    output logic      o_srsp_sio_oe,
    output logic      o_srsp_err
);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_IGNORE
    } state_t;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIB - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [23:0]         sh_q, sh_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                sck_q;
    logic                rd_q, rd_d;
    logic                err_q, err_d;
    logic                lo_q, lo_d;
    logic                rd_rise_q, rd_rise_d;
    logic                hi_vld_q, hi_vld_d;
    logic [3:0]          hi_q, hi_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          mem_q [2**ADDR_W];

    logic                rise, fall;
    logic [23:0]         shifted;
    logic                unused_sh;

    assign rise      = i_srsp_sck & ~sck_q;
    assign fall      = ~i_srsp_sck & sck_q;
    assign shifted   = {sh_q[19:0], i_srsp_sio};
    assign unused_sh = ^sh_q[23:20];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        err_d     = err_q;
        lo_d      = lo_q;
        rd_rise_d = rd_rise_q;
        hi_vld_d  = hi_vld_q;
        hi_d      = hi_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;

        // A completed write byte lands this cycle; step past it.
        if (we_q) addr_d = addr_q + 1'b1;

        if (i_srsp_cs) begin
            state_d   = S_CMD;
            cnt_d     = '0;
            lo_d      = 1'b0;
            rd_rise_d = 1'b0;
            hi_vld_d  = 1'b0;
        end else begin
            if (rise) begin
                unique case (state_q)
                    S_CMD: begin
                        sh_d = shifted;
                        if (cnt_q == 8'd1) begin
                            cnt_d = '0;
                            if (shifted[7:0] == 8'h03) begin
                                rd_d    = 1'b1;
                                state_d = S_ADDR;
                            end else if (shifted[7:0] == 8'h02) begin
                                rd_d    = 1'b0;
                                state_d = S_ADDR;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    S_ADDR: begin
                        sh_d = shifted;
                        if (cnt_q == 8'd5) begin
                            cnt_d  = '0;
                            addr_d = shifted[ADDR_W-1:0];
                            lo_d   = 1'b0;
                            if (!rd_q)              state_d = S_WR;
                            else if (DUMMY_NIB == 0) state_d = S_RD;
                            else                     state_d = S_DUMMY;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    S_DUMMY: begin
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d   = '0;
                            state_d = S_RD;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    S_RD: rd_rise_d = 1'b1;
                    S_WR: begin
                        if (!hi_vld_q) begin
                            hi_d     = i_srsp_sio;
                            hi_vld_d = 1'b1;
                        end else begin
                            wdata_d  = {hi_q, i_srsp_sio};
                            we_d     = 1'b1;
                            hi_vld_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            // Output only advances on a fall that closes a rise seen in RD,
            // so the fall after the last dummy nibble keeps the high nibble.
            if (fall && state_q == S_RD && rd_rise_q) begin
                rd_rise_d = 1'b0;
                if (lo_q) begin
                    lo_d   = 1'b0;
                    addr_d = addr_q + 1'b1;
                end else begin
                    lo_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_srsp_gck or posedge i_srsp_rst) begin
        if (i_srsp_rst) begin
            state_q   <= S_CMD;
            cnt_q     <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            sck_q     <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            lo_q      <= 1'b0;
            rd_rise_q <= 1'b0;
            hi_vld_q  <= 1'b0;
            hi_q      <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            addr_q    <= addr_d;
            sck_q     <= i_srsp_sck;
            rd_q      <= rd_d;
            err_q     <= err_d;
            lo_q      <= lo_d;
            rd_rise_q <= rd_rise_d;
            hi_vld_q  <= hi_vld_d;
            hi_q      <= hi_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge i_srsp_gck) begin
        if (we_q) mem_q[addr_q] <= wdata_q;
    end

    assign o_srsp_sio_oe = (state_q == S_RD);
    assign o_srsp_err    = err_q;

    always_comb begin
        o_srsp_sio = '0;
        unique case (1'b1)
            !o_srsp_sio_oe: o_srsp_sio = '0;
            lo_q:           o_srsp_sio = mem_q[addr_q][3:0];
            default:        o_srsp_sio = mem_q[addr_q][7:4];
        endcase
    end

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// Directed bench for idli_sqi_resp_m: byte-level memory model predicts
// every read nibble, oe and err; literal values pin the model.
module tb_idli_sqi_resp_m;

    logic       gck = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic       oe;
    logic       err;

    idli_sqi_resp_m #(.ADDR_W(8), .DUMMY_NIB(2)) dut (
        .i_srsp_gck    (gck),
        .i_srsp_rst    (rst),
        .i_srsp_sck    (sck),
        .i_srsp_cs     (cs),
        .i_srsp_sio    (sio_i),
        .o_srsp_sio    (sio_o),
        .o_srsp_sio_oe (oe),
        .o_srsp_err    (err)
    );

    always #5 gck = ~gck;

    int         checks = 0;
    int         errors = 0;
    logic       chk_en = 1'b0;
    logic       e_oe   = 1'b0;
    logic [3:0] e_sio  = 4'h0;
    logic       m_err  = 1'b0;
    logic [7:0] mem_m [256];
    logic [3:0] rx;
    logic [3:0] got [16];
    logic [7:0] wb [8];

    // Per-cycle comparison against the model in stable windows.
    always @(posedge gck) begin
        #1;
        if (chk_en) begin
            checks++;
            if (oe !== e_oe || sio_o !== e_sio || err !== m_err) begin
                errors++;
                $display("FAIL cycle t=%0t oe/sio/err got %b/%h/%b want %b/%h/%b",
                         $time, oe, sio_o, err, e_oe, e_sio, m_err);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] g, input logic [7:0] w);
        checks++;
        if (g !== w) begin
            errors++;
            $display("FAIL %s got %h want %h", name, g, w);
        end
    endtask

    // One nibble: low phase (data set, outputs checked), then high phase.
    task automatic nib(input logic [3:0] n, input logic eo, input logic [3:0] es);
        @(negedge gck);
        sck = 1'b0; sio_i = n; e_oe = eo; e_sio = es; chk_en = 1'b0;
        @(negedge gck);
        chk_en = 1'b1;
        @(negedge gck);
        @(negedge gck);
        rx = sio_o; chk_en = 1'b0; sck = 1'b1;
        @(negedge gck);
        @(negedge gck);
    endtask

    task automatic cs_down();
        @(negedge gck);
        cs = 1'b0;
        @(negedge gck);
    endtask

    task automatic cs_up();
        @(negedge gck);
        sck = 1'b0; cs = 1'b1; sio_i = 4'h0;
        e_oe = 1'b0; e_sio = 4'h0; chk_en = 1'b0;
        @(negedge gck);
        chk_en = 1'b1;
        @(negedge gck);
        @(negedge gck);
        chk_en = 1'b0;
    endtask

    task automatic hdr(input logic [7:0] c, input logic [23:0] a);
        nib(c[7:4], 1'b0, 4'h0);
        nib(c[3:0], 1'b0, 4'h0);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4], 1'b0, 4'h0);
    endtask

    task automatic wr(input logic [23:0] a, input int nb);
        cs_down();
        hdr(8'h02, a);
        for (int i = 0; i < nb; i++) begin
            nib(wb[i][7:4], 1'b0, 4'h0);
            nib(wb[i][3:0], 1'b0, 4'h0);
            mem_m[8'(a + 24'(i))] = wb[i];
        end
        cs_up();
    endtask

    task automatic rd_body(input logic [23:0] a, input int nb);
        logic [7:0] b;
        hdr(8'h03, a);
        nib(4'h6, 1'b0, 4'h0);
        nib(4'h9, 1'b0, 4'h0);
        for (int k = 0; k < 2 * nb; k++) begin
            b = mem_m[8'(a + 24'(k / 2))];
            nib(4'h0, 1'b1, (k % 2 == 1) ? b[3:0] : b[7:4]);
            got[k] = rx;
        end
    endtask

    task automatic rd(input logic [23:0] a, input int nb);
        cs_down();
        rd_body(a, nb);
        cs_up();
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; sio_i = 4'h0;
        repeat (3) @(negedge gck);
        #1;
        chk("reset_oe", 8'(oe), 8'h0);
        chk("reset_sio", 8'(sio_o), 8'h0);
        chk("reset_err", 8'(err), 8'h0);
        @(negedge gck);
        rst = 1'b0;
        repeat (2) @(negedge gck);

        // Write / read back at 0x10
        wb[0] = 8'hA5; wb[1] = 8'h3C;
        wr(24'h000010, 2);
        rd(24'h000010, 2);
        chk("rd10_n0", 8'(got[0]), 8'h0A);
        chk("rd10_n1", 8'(got[1]), 8'h05);
        chk("rd10_n2", 8'(got[2]), 8'h03);
        chk("rd10_n3", 8'(got[3]), 8'h0C);

        // Burst write across the top of the address space
        wb[0] = 8'hEE; wb[1] = 8'h11;
        wr(24'h0000FF, 2);

        // Unsupported command, then a normal read
        cs_down();
        nib(4'h9, 1'b0, 4'h0);
        nib(4'hF, 1'b0, 4'h0);
        m_err = 1'b1;
        for (int k = 0; k < 8; k++) nib(4'(k * 3 + 1), 1'b0, 4'h0);
        cs_up();
        rd(24'h0000FF, 2);
        chk("wrap_n0", 8'(got[0]), 8'h0E);
        chk("wrap_n1", 8'(got[1]), 8'h0E);
        chk("wrap_n2", 8'(got[2]), 8'h01);
        chk("wrap_n3", 8'(got[3]), 8'h01);
        chk("err_sticky", 8'(err), 8'h1);

        // Partial write byte dropped when cs rises
        wb[0] = 8'h00; wb[1] = 8'h5A;
        wr(24'h000020, 2);
        cs_down();
        hdr(8'h02, 24'h000020);
        nib(4'h7, 1'b0, 4'h0);
        nib(4'h7, 1'b0, 4'h0);
        nib(4'h4, 1'b0, 4'h0);
        mem_m[8'h20] = 8'h77;
        cs_up();
        rd(24'h000020, 2);
        chk("part_n0", 8'(got[0]), 8'h07);
        chk("part_n1", 8'(got[1]), 8'h07);
        chk("part_n2", 8'(got[2]), 8'h05);
        chk("part_n3", 8'(got[3]), 8'h0A);

        // Aborted address, then fresh address with non-zero upper bits
        cs_down();
        nib(4'h0, 1'b0, 4'h0);
        nib(4'h3, 1'b0, 4'h0);
        nib(4'hF, 1'b0, 4'h0);
        nib(4'hF, 1'b0, 4'h0);
        nib(4'hF, 1'b0, 4'h0);
        cs_up();
        rd(24'hAB0010, 1);
        chk("fresh_n0", 8'(got[0]), 8'h0A);
        chk("fresh_n1", 8'(got[1]), 8'h05);

        // Reset in the middle of a read
        cs_down();
        rd_body(24'h000010, 1);
        @(negedge gck);
        rst = 1'b1;
        #1;
        chk("rst_oe", 8'(oe), 8'h0);
        chk("rst_sio", 8'(sio_o), 8'h0);
        chk("rst_err", 8'(err), 8'h0);
        m_err = 1'b0;
        @(negedge gck);
        cs = 1'b1; sck = 1'b0;
        @(negedge gck);
        rst = 1'b0;
        repeat (2) @(negedge gck);
        rd(24'h000010, 2);
        chk("post_n0", 8'(got[0]), 8'h0A);
        chk("post_n1", 8'(got[1]), 8'h05);
        chk("post_n2", 8'(got[2]), 8'h03);
        chk("post_n3", 8'(got[3]), 8'h0C);

        repeat (2) @(negedge gck);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idli_sqi_resp_m.md
IDLI_SQI_RESP_M -- requirements
Module: idli_sqi_resp_m

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, storage address width in bits (2^ADDR_W bytes).
REQ-002 SHALL have parameter DUMMY_NIB, default 2, number of dummy nibbles between the READ address and the first read data.
REQ-003 SHALL have port i_srsp_gck, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port i_srsp_rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port i_srsp_sck, input, 1, serial clock from the SQI initiator, synchronous to i_srsp_gck.
REQ-006 SHALL have port i_srsp_cs, input, 1, chip select, active-low.
REQ-007 SHALL have port i_srsp_sio, input, sqi_data_t (4), nibble driven by the initiator.
REQ-008 SHALL have port o_srsp_sio, output, sqi_data_t (4), nibble driven to the initiator.
REQ-009 SHALL have port o_srsp_sio_oe, output, 1, high while the responder drives o_srsp_sio.
REQ-010 SHALL have port o_srsp_err, output, 1, sticky flag: unsupported command received.

Function
REQ-011 SHALL register i_srsp_sck each cycle and define rise = sck & ~sck_q and fall = ~sck & sck_q.
REQ-012 SHALL sample i_srsp_sio only in cycles with rise and i_srsp_cs low; all other cycles leave shift state unchanged.
REQ-013 SHALL implement states CMD, ADDR, DUMMY, RD, WR, IGNORE, with a nibble counter and a 24-bit address shift register.
REQ-014 SHALL treat all multi-nibble fields as MSB-first; within each byte, the high nibble comes first.
REQ-015 CMD: SHALL collect 2 nibbles; command 0x03 selects read and 0x02 selects write, both then going to ADDR; any other command goes to IGNORE and sets o_srsp_err.
REQ-016 ADDR: SHALL collect 6 nibbles (24 bits); only bits [ADDR_W-1:0] are used and upper bits are ignored; then go to DUMMY for read or WR for write.
REQ-017 DUMMY: SHALL count DUMMY_NIB rises, ignoring the data, then enter RD; if DUMMY_NIB is 0, SHALL enter RD directly from ADDR.
REQ-018 RD entry: in the cycle after entering RD, o_srsp_sio SHALL equal mem[addr][7:4] and o_srsp_sio_oe SHALL be 1.
REQ-019 RD: in the cycle after each fall that follows a rise in RD, the output SHALL advance: high nibble to low nibble, or low nibble to the high nibble of mem[addr+1].
REQ-020 WR: the first rise SHALL capture the high nibble; the second rise SHALL complete the byte; mem[addr] SHALL be written in the following cycle and addr incremented.
REQ-021 Address increment SHALL be modulo 2^ADDR_W; 0xFF+1 wraps to 0x00 at the default ADDR_W.
REQ-022 IGNORE: SHALL disregard all sio until i_srsp_cs goes high; o_srsp_sio_oe SHALL stay 0.
REQ-023 i_srsp_cs high in any state SHALL, in the next cycle: force state CMD, clear the counter, and set o_srsp_sio_oe to 0.
REQ-024 A write byte with only its high nibble received when cs rises SHALL be discarded; memory is unchanged.
REQ-025 A rise coincident with cs going high SHALL be ignored.
REQ-026 o_srsp_sio_oe SHALL be 1 only in RD; o_srsp_sio SHALL be 0 whenever oe is 0.
REQ-027 Sequential transfers SHALL be unbounded in length while cs stays low.
REQ-028 o_srsp_err SHALL remain set until reset, across transactions.

Reset
REQ-029 On i_srsp_rst high, asynchronously: state CMD, counter 0, address 0, sck_q 0, o_srsp_sio 0, o_srsp_sio_oe 0, o_srsp_err 0.
REQ-030 Reset mid-transaction SHALL abort it; an incomplete write byte is not written.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 After reset release, the first rise with cs low SHALL be treated as command nibble 0.

Verification
REQ-033 Write 0x02, addr 0x000010, data 0xA5,0x3C; then read 0x03, addr 0x000010, 2 dummy nibbles -> sio shows A,5,3,C with oe=1.
REQ-034 Write 0xEE at 0xFF and 0x11 at 0x00 in one burst -> wraps; a read from 0xFF returns EE,11.
REQ-035 Command 0x9F -> o_srsp_err=1, oe stays 0 for 8 further rises; next transaction 0x03 works and err is still 1.
REQ-036 Write to 0x20: send 0x77, then high nibble 0x4, then raise cs -> read of 0x20/0x21 returns 0x77 then the prior contents.
REQ-037 Assert i_srsp_rst during RD -> oe=0 and sio=0 immediately (asynchronously); err=0; a new read transaction succeeds.
REQ-038 Raise cs after the 3rd address nibble, then start a new read -> the new address is decoded from fresh nibbles, with no residue.
